// File: rtl/cnn_layer_accel_pixel_feeder_if.sv
// cnn_layer_accel_pixel_feeder_if
// Config, job control, memory and pixel handshakes of the pixel feeder.
interface cnn_layer_accel_pixel_feeder_if #(
  parameter int C_PIXEL_WIDTH   = 16,
  parameter int C_NUM_CHANNELS  = 8,
  parameter int C_ROW_CNT_WIDTH = 10,
  parameter int C_COL_CNT_WIDTH = 10,
  parameter int C_ADDR_WIDTH    = 20
) ();
  localparam int DW = C_NUM_CHANNELS * C_PIXEL_WIDTH;

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [C_ROW_CNT_WIDTH-1:0] cfg_num_rows;
  logic [C_COL_CNT_WIDTH-1:0] cfg_num_cols;
  logic [C_ADDR_WIDTH-1:0]    cfg_base_addr;
  logic                       cfg_pad_en;

  logic                       job_fetch_request;
  logic                       job_fetch_ack;
  logic                       job_fetch_complete;
  logic                       job_done;
  logic                       job_done_ack;

  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic [C_ADDR_WIDTH-1:0]    mem_req_addr;
  logic                       mem_rsp_valid;
  logic                       mem_rsp_ready;
  logic [DW-1:0]              mem_rsp_data;

  logic                       pixel_valid;
  logic                       pixel_ready;
  logic [DW-1:0]              pixel_data;

  modport master (
    input  cfg_valid,
    output cfg_ready,
    input  cfg_num_rows,
    input  cfg_num_cols,
    input  cfg_base_addr,
    input  cfg_pad_en,
    input  job_fetch_request,
    output job_fetch_ack,
    output job_fetch_complete,
    output job_done,
    input  job_done_ack,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    input  mem_rsp_valid,
    output mem_rsp_ready,
    input  mem_rsp_data,
    output pixel_valid,
    input  pixel_ready,
    output pixel_data
  );

  modport slave (
    output cfg_valid,
    input  cfg_ready,
    output cfg_num_rows,
    output cfg_num_cols,
    output cfg_base_addr,
    output cfg_pad_en,
    output job_fetch_request,
    input  job_fetch_ack,
    input  job_fetch_complete,
    input  job_done,
    output job_done_ack,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    output mem_rsp_valid,
    input  mem_rsp_ready,
    output mem_rsp_data,
    input  pixel_valid,
    output pixel_ready,
    input  pixel_data
  );
endinterface

// File: rtl/cnn_layer_accel_pixel_feeder.sv
// cnn_layer_accel_pixel_feeder
// Fetches one row of channel-packed pixel words per request, optional zero pads.
module cnn_layer_accel_pixel_feeder #(
  parameter int C_PIXEL_WIDTH   = 16,
  parameter int C_NUM_CHANNELS  = 8,
  parameter int C_ROW_CNT_WIDTH = 10,
  parameter int C_COL_CNT_WIDTH = 10,
  parameter int C_ADDR_WIDTH    = 20
) (
  input  logic clk_if,
  input  logic rst,
  cnn_layer_accel_pixel_feeder_if.master bus
);
  localparam int DW = C_NUM_CHANNELS * C_PIXEL_WIDTH;
  localparam int RW = C_ROW_CNT_WIDTH;
  localparam int CW = C_COL_CNT_WIDTH;
  localparam int AW = C_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_ACK,
    S_PAD_L,
    S_STREAM,
    S_PAD_R,
    S_COMPLETE,
    S_DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [RW-1:0] num_rows_q;
  logic [CW-1:0] num_cols_q;
  logic          pad_en_q;
  logic [RW-1:0] row_cnt_q;
  logic [CW:0]   req_cnt_q;
  logic [CW-1:0] beat_cnt_q;
  logic [AW-1:0] addr_q;

  logic          cfg_ready_r;
  logic          ack_r;
  logic          cmpl_r;
  logic          done_r;
  logic          mreq_v_r;
  logic          mrsp_rdy_r;
  logic          pv_r;
  logic [DW-1:0] pd_r;

  logic          cfg_fire;
  logic          req_fire;
  logic          beat_fire;
  logic          last_beat;
  logic          last_row;
  logic          req_open;

  assign cfg_fire  = (state_q == S_IDLE) & bus.cfg_valid;
  assign req_fire  = mreq_v_r & bus.mem_req_ready;
  assign beat_fire = (state_q == S_STREAM)
                   & bus.mem_rsp_valid
                   & bus.pixel_ready;
  assign last_beat = (beat_cnt_q == num_cols_q);
  assign last_row  = (row_cnt_q == num_rows_q);
  assign req_open  = (req_cnt_q <= {1'b0, num_cols_q});

  // State register
  always_ff @(posedge clk_if) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and raw (pre-reset-gating) outputs
  always_comb begin
    state_d     = state_q;
    cfg_ready_r = 1'b0;
    ack_r       = 1'b0;
    cmpl_r      = 1'b0;
    done_r      = 1'b0;
    mreq_v_r    = 1'b0;
    mrsp_rdy_r  = 1'b0;
    pv_r        = 1'b0;
    pd_r        = '0;
    unique case (state_q)
      S_IDLE: begin
        cfg_ready_r = 1'b1;
        if (bus.cfg_valid) begin
          state_d = S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: begin
        if (bus.job_fetch_request) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_r   = 1'b1;
        state_d = pad_en_q ? S_PAD_L : S_STREAM;
      end
      S_PAD_L: begin
        pv_r = 1'b1;
        if (bus.pixel_ready) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        mreq_v_r   = req_open;
        pv_r       = bus.mem_rsp_valid;
        pd_r       = bus.mem_rsp_data;
        mrsp_rdy_r = bus.pixel_ready;
        if (beat_fire && last_beat) begin
          state_d = pad_en_q ? S_PAD_R : S_COMPLETE;
        end
      end
      S_PAD_R: begin
        pv_r = 1'b1;
        if (bus.pixel_ready) begin
          state_d = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        cmpl_r  = 1'b1;
        state_d = last_row ? S_DONE : S_WAIT_REQ;
      end
      S_DONE: begin
        done_r = 1'b1;
        if (bus.job_done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latched job configuration
  always_ff @(posedge clk_if) begin
    if (rst) begin
      num_rows_q <= '0;
      num_cols_q <= '0;
      pad_en_q   <= 1'b0;
    end else if (cfg_fire) begin
      num_rows_q <= bus.cfg_num_rows;
      num_cols_q <= bus.cfg_num_cols;
      pad_en_q   <= bus.cfg_pad_en;
    end
  end

  // Row counter, advanced as each row completes
  always_ff @(posedge clk_if) begin
    if (rst) begin
      row_cnt_q <= '0;
    end else if (cfg_fire) begin
      row_cnt_q <= '0;
    end else if (state_q == S_COMPLETE && !last_row) begin
      row_cnt_q <= row_cnt_q + RW'(1);
    end
  end

  // Word address; runs on across rows and wraps at the top
  always_ff @(posedge clk_if) begin
    if (rst) begin
      addr_q <= '0;
    end else if (cfg_fire) begin
      addr_q <= bus.cfg_base_addr;
    end else if (req_fire) begin
      addr_q <= addr_q + AW'(1);
    end
  end

  // Per-row count of issued memory requests
  always_ff @(posedge clk_if) begin
    if (rst) begin
      req_cnt_q <= '0;
    end else if (state_q == S_ACK) begin
      req_cnt_q <= '0;
    end else if (req_fire) begin
      req_cnt_q <= req_cnt_q + (CW+1)'(1);
    end
  end

  // Per-row count of delivered data beats
  always_ff @(posedge clk_if) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (state_q == S_ACK) begin
      beat_cnt_q <= '0;
    end else if (beat_fire && !last_beat) begin
      beat_cnt_q <= beat_cnt_q + CW'(1);
    end
  end

  // Every output is forced low while reset is held
  assign bus.cfg_ready          = cfg_ready_r & ~rst;
  assign bus.job_fetch_ack      = ack_r & ~rst;
  assign bus.job_fetch_complete = cmpl_r & ~rst;
  assign bus.job_done           = done_r & ~rst;
  assign bus.mem_req_valid      = mreq_v_r & ~rst;
  assign bus.mem_req_addr       = rst ? '0 : addr_q;
  assign bus.mem_rsp_ready      = mrsp_rdy_r & ~rst;
  assign bus.pixel_valid        = pv_r & ~rst;
  assign bus.pixel_data         = rst ? '0 : pd_r;

endmodule

// File: tb/tb_cnn_layer_accel_pixel_feeder.sv
// tb_cnn_layer_accel_pixel_feeder
// Directed table plus random jobs against a row-level reference model.
module tb_cnn_layer_accel_pixel_feeder;
  localparam int PW = 16;
  localparam int NC = 8;
  localparam int RW = 10;
  localparam int CW = 10;
  localparam int AW = 20;
  localparam int DW = PW * NC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_pixel_feeder_if #(
    .C_PIXEL_WIDTH(PW), .C_NUM_CHANNELS(NC),
    .C_ROW_CNT_WIDTH(RW), .C_COL_CNT_WIDTH(CW),
    .C_ADDR_WIDTH(AW)
  ) bus ();

  cnn_layer_accel_pixel_feeder #(
    .C_PIXEL_WIDTH(PW), .C_NUM_CHANNELS(NC),
    .C_ROW_CNT_WIDTH(RW), .C_COL_CNT_WIDTH(CW),
    .C_ADDR_WIDTH(AW)
  ) dut (
    .clk_if(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;
  int mreq_pct = 100;
  int mrsp_pct = 100;
  int acks, cmpls, viol;

  logic [AW-1:0] mem_q[$];
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_pix[$];

  typedef struct {
    int            rows;
    int            cols;
    bit            pad;
    logic [AW-1:0] base;
    int            rdy;
    int            mreq;
    int            beats;
    int            reqs;
    logic [AW-1:0] last_addr;
  } vec_t;

  vec_t tv[5];

  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    logic [DW-1:0] w;
    logic [15:0] hi;
    hi = {a[19:16], 12'h000};
    for (int ch = 0; ch < NC; ch++) begin
      w[ch*PW +: PW] = (a[15:0] + 16'(ch) * 16'h1357 + 16'h0101) ^ hi;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Observe handshakes on the active edge (pre-update values)
  always @(posedge clk) begin
    if (rst) begin
      mem_q.delete();
    end else begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        mem_q.push_back(bus.mem_req_addr);
        got_addr.push_back(bus.mem_req_addr);
      end
      if (bus.mem_rsp_valid && bus.mem_rsp_ready && mem_q.size() > 0)
        void'(mem_q.pop_front());
      if (bus.pixel_valid && bus.pixel_ready)
        got_pix.push_back(bus.pixel_data);
      if (bus.job_fetch_ack) acks++;
      if (bus.job_fetch_complete) cmpls++;
      if (bus.mem_rsp_ready && !bus.pixel_ready) viol++;
    end
  end

  // Memory responder and pixel sink, driven on the falling edge
  always @(negedge clk) begin
    bus.pixel_ready   = ($urandom_range(0, 99) < rdy_pct);
    bus.mem_req_ready = ($urandom_range(0, 99) < mreq_pct);
    if (mem_q.size() > 0 && $urandom_range(0, 99) < mrsp_pct) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = mem_word(mem_q[0]);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = {4{$urandom}};
    end
  end

  task automatic start_job(input int rows, input int cols, input bit pad,
                           input logic [AW-1:0] base, input bit noise);
    acks = 0;
    cmpls = 0;
    viol = 0;
    got_addr.delete();
    got_pix.delete();
    chk("cfg_ready_before_job", longint'(bus.cfg_ready), 1);
    bus.cfg_num_rows  = RW'(rows);
    bus.cfg_num_cols  = CW'(cols);
    bus.cfg_pad_en    = pad;
    bus.cfg_base_addr = base;
    bus.cfg_valid     = 1'b1;
    tick();
    bus.cfg_valid = noise;
    if (noise) begin
      bus.cfg_num_rows  = RW'($urandom);
      bus.cfg_num_cols  = CW'($urandom);
      bus.cfg_pad_en    = ~pad;
      bus.cfg_base_addr = AW'($urandom);
    end
  endtask

  task automatic finish_job(input string nm, input int rows, input int cols,
                            input bit pad, input logic [AW-1:0] base,
                            input int exp_beats, input int exp_reqs,
                            input logic [AW-1:0] exp_last);
    logic [DW-1:0] exp_pix[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] a;
    int n;
    int bad;
    n = 0;
    while (!bus.job_done && n < 5000) begin
      tick();
      n++;
    end
    bus.job_fetch_request = 1'b0;
    bus.cfg_valid = 1'b0;
    if (!bus.job_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: job_done never seen in %0d cycles", nm, n);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      return;
    end
    for (int r = 0; r <= rows; r++) begin
      if (pad) exp_pix.push_back('0);
      for (int c = 0; c <= cols; c++) begin
        a = base + AW'(r * (cols + 1) + c);
        exp_addr.push_back(a);
        exp_pix.push_back(mem_word(a));
      end
      if (pad) exp_pix.push_back('0);
    end
    chk({nm, "_beats"}, got_pix.size(), exp_beats);
    chk({nm, "_reqs"}, got_addr.size(), exp_reqs);
    chk({nm, "_last_addr"},
        got_addr.size() > 0 ? longint'(got_addr[got_addr.size()-1]) : -1,
        longint'(exp_last));
    chk({nm, "_acks"}, acks, rows + 1);
    chk({nm, "_completes"}, cmpls, rows + 1);
    chk({nm, "_rsp_ready_follows"}, viol, 0);
    bad = -1;
    for (int i = 0; i < exp_pix.size(); i++)
      if (bad < 0 && (i >= got_pix.size() || got_pix[i] !== exp_pix[i]))
        bad = i;
    chk({nm, "_pixel_order_first_bad"}, bad, -1);
    bad = -1;
    for (int i = 0; i < exp_addr.size(); i++)
      if (bad < 0 && (i >= got_addr.size() || got_addr[i] !== exp_addr[i]))
        bad = i;
    chk({nm, "_addr_order_first_bad"}, bad, -1);
    repeat (3) tick();
    chk({nm, "_done_held"}, longint'(bus.job_done), 1);
    bus.job_done_ack = 1'b1;
    tick();
    bus.job_done_ack = 1'b0;
    chk({nm, "_done_cleared"}, longint'(bus.job_done), 0);
    chk({nm, "_cfg_ready_after"}, longint'(bus.cfg_ready), 1);
  endtask

  initial begin
    int n;
    int rr, cc;
    bit pp;
    logic [AW-1:0] bb;
    tv[0] = '{9, 9, 1'b0, 20'h00100, 100, 100, 100, 100, 20'h00163};
    tv[1] = '{0, 3, 1'b1, 20'h00200,  70,  70,   6,   4, 20'h00203};
    tv[2] = '{0, 9, 1'b0, 20'h003A0,  50,  70,  10,  10, 20'h003A9};
    tv[3] = '{0, 0, 1'b0, 20'h00055,  70,  70,   1,   1, 20'h00055};
    tv[4] = '{0, 3, 1'b0, 20'hFFFFE,  70,  70,   4,   4, 20'h00001};

    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_num_rows = '0;
    bus.cfg_num_cols = '0;
    bus.cfg_base_addr = '0;
    bus.cfg_pad_en = 1'b0;
    bus.job_fetch_request = 1'b0;
    bus.job_done_ack = 1'b0;
    repeat (3) tick();
    chk("rst_cfg_ready", longint'(bus.cfg_ready), 0);
    chk("rst_pixel_valid", longint'(bus.pixel_valid), 0);
    chk("rst_mem_req_valid", longint'(bus.mem_req_valid), 0);
    chk("rst_job_done", longint'(bus.job_done), 0);
    rst = 1'b0;
    #1;
    chk("cfg_ready_first_cycle", longint'(bus.cfg_ready), 1);
    tick();

    // Ack timing: request ignored until raised, ack for exactly one cycle
    rdy_pct = 100;
    mreq_pct = 100;
    mrsp_pct = 100;
    start_job(0, 0, 1'b0, 20'h00777, 1'b0);
    tick();
    tick();
    chk("no_ack_without_request", longint'(bus.job_fetch_ack), 0);
    bus.job_fetch_request = 1'b1;
    tick();
    chk("ack_next_cycle", longint'(bus.job_fetch_ack), 1);
    bus.job_fetch_request = 1'b0;
    tick();
    chk("ack_one_cycle", longint'(bus.job_fetch_ack), 0);
    bus.job_done_ack = 1'b1;
    tick();
    bus.job_done_ack = 1'b0;
    chk("done_ack_outside_done_ignored", longint'(bus.cfg_ready), 0);
    finish_job("latency", 0, 0, 1'b0, 20'h00777, 1, 1, 20'h00777);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      rdy_pct = tv[i].rdy;
      mreq_pct = tv[i].mreq;
      mrsp_pct = (i == 0) ? 100 : 60;
      start_job(tv[i].rows, tv[i].cols, tv[i].pad, tv[i].base, 1'b0);
      bus.job_fetch_request = 1'b1;
      finish_job($sformatf("vec%0d", i), tv[i].rows, tv[i].cols,
                 tv[i].pad, tv[i].base, tv[i].beats, tv[i].reqs,
                 tv[i].last_addr);
    end

    // Random jobs, with config noise while busy
    for (int j = 0; j < 6; j++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 7);
      pp = 1'($urandom_range(0, 1));
      bb = ($urandom_range(0, 1) == 1) ? AW'($urandom)
                                        : AW'(20'hFFFFF - $urandom_range(0, 8));
      rdy_pct = $urandom_range(30, 100);
      mreq_pct = $urandom_range(30, 100);
      mrsp_pct = $urandom_range(30, 100);
      start_job(rr, cc, pp, bb, 1'b1);
      bus.job_fetch_request = 1'b1;
      finish_job($sformatf("rand%0d", j), rr, cc, pp, bb,
                 (rr + 1) * (cc + 1 + (pp ? 2 : 0)),
                 (rr + 1) * (cc + 1),
                 bb + AW'((rr + 1) * (cc + 1) - 1));
    end

    // Reset in the middle of a stream
    rdy_pct = 100;
    mreq_pct = 100;
    mrsp_pct = 100;
    start_job(3, 9, 1'b0, 20'h00040, 1'b0);
    bus.job_fetch_request = 1'b1;
    n = 0;
    while (got_pix.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_stream_reached", got_pix.size() >= 3, 1);
    rst = 1'b1;
    bus.job_fetch_request = 1'b0;
    tick();
    chk("rst_mid_pixel_valid", longint'(bus.pixel_valid), 0);
    chk("rst_mid_mem_req_valid", longint'(bus.mem_req_valid), 0);
    chk("rst_mid_mem_rsp_ready", longint'(bus.mem_rsp_ready), 0);
    chk("rst_mid_cfg_ready", longint'(bus.cfg_ready), 0);
    chk("rst_mid_mem_req_addr", longint'(bus.mem_req_addr), 0);
    chk("rst_mid_pixel_data_zero", longint'(bus.pixel_data == '0), 1);
    rst = 1'b0;
    tick();
    chk("cfg_ready_after_rst", longint'(bus.cfg_ready), 1);
    rdy_pct = 80;
    mreq_pct = 80;
    mrsp_pct = 80;
    start_job(1, 2, 1'b1, 20'h00010, 1'b0);
    bus.job_fetch_request = 1'b1;
    finish_job("post_rst", 1, 2, 1'b1, 20'h00010, 10, 6, 20'h00015);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
